// File: rtl/aes_out_collector.sv
// -----------------------------------------------------------------------------
// aes_out_collector
//
// Stream adapter wrapped around a fixed-latency, non-stallable AES-256
// pipeline core. Blocks are admitted upstream only when the output FIFO is
// guaranteed to have room for them on arrival (credit = FIFO level plus
// blocks still inside the core), so a finished ciphertext never has to be
// dropped even though the core itself cannot be stalled.
//
// Handshake rule for both stream sides: a transfer happens on the rising
// edge where valid and ready are both high; valid never depends on ready,
// and once out_valid is raised it stays up, with out_data stable, until the
// transfer happens.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream presents a state/key to the core this cycle
//   in_ready   issue slot granted (block issued when in_valid & in_ready)
//   core_out   ciphertext from the core output register
//   out_valid  out_data holds a ciphertext
//   out_ready  downstream accepts out_data
//   out_data   head of the output FIFO
//   in_flight  blocks issued but not yet captured into the FIFO
//   level      FIFO occupancy
// -----------------------------------------------------------------------------
module aes_out_collector #(
    parameter int LATENCY = 15,
    parameter int DEPTH   = 32,
    parameter int WIDTH   = 128
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                core_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [$clog2(LATENCY+2)-1:0]    in_flight,
    output logic [$clog2(DEPTH+1)-1:0]      level
);

    localparam int AW  = $clog2(DEPTH);
    localparam int IFW = $clog2(LATENCY + 2);
    localparam int LW  = $clog2(DEPTH + 1);
    localparam logic [31:0] DEPTH_U = DEPTH;

    logic [LATENCY:0]  vsr_q, vsr_d;
    logic [IFW-1:0]    in_flight_q, in_flight_d;
    logic [LW-1:0]     level_q, level_d;
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic issue;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    // Credit check uses registered state only, so in_ready has no
    // combinational path from in_valid, out_ready or the current pop.
    assign in_ready  = (32'(level_q) + 32'(in_flight_q)) < DEPTH_U;
    assign out_valid = (level_q != '0);
    assign out_data  = mem[rptr_q[AW-1:0]];
    assign in_flight = in_flight_q;
    assign level     = level_q;

    assign issue = in_valid & in_ready;
    // vsr[LATENCY] is high exactly in the cycle core_out carries that block.
    assign push  = vsr_q[LATENCY];
    assign pop   = out_valid & out_ready;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifo_empty = (wptr_q == rptr_q);

    always_comb begin
        vsr_d       = {vsr_q[LATENCY-1:0], issue};
        in_flight_d = in_flight_q + IFW'(issue) - IFW'(push);
        level_d     = level_q + LW'(push) - LW'(pop);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr_q       <= '0;
            in_flight_q <= '0;
            level_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            vsr_q       <= vsr_d;
            in_flight_q <= in_flight_d;
            level_q     <= level_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    // Storage is deliberately not reset; out_data is only meaningful while
    // out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= core_out;
        end
    end

    // The credit rule must make a push into a full FIFO impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full));

    a_empty_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_empty == !out_valid);

endmodule
